// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//
// Flow-controlled IF/ID pipeline register. Carries the fetched PC and
// instruction from fetch to decode with a valid/ready handshake. With
// SKID_EN=1 a second (skid) entry absorbs the beat that fetch launched while
// decode was stalling, so in_ready can come straight from a flop. With
// SKID_EN=0 only one entry exists and in_ready is the usual combinational
// "empty or draining" term.
//
// IF_Flush (taken branch / jump) empties the register and presents a bubble:
// out_valid=0, outPC=0, outInstruction=NOP_INSTR.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset (highest priority)
//   in_valid       in   fetch offers a beat
//   in_ready       out  register accepts a beat this cycle
//   inPC           in   PC_WIDTH    incremented PC from fetch
//   inInstruction  in   INSTR_WIDTH fetched instruction
//   IF_Flush       in   drop all held and incoming instructions
//   out_valid      out  outPC/outInstruction hold a valid instruction
//   out_ready      in   decode accepts this cycle
//   outPC          out  PC_WIDTH    presented PC (0 when out_valid=0)
//   outInstruction out  INSTR_WIDTH presented instruction (NOP_INSTR when idle)
//   occupancy      out  number of held entries (0..2)
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'hF800_0000,
    parameter bit                     SKID_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_WIDTH-1:0]    inPC,
    input  logic [INSTR_WIDTH-1:0] inInstruction,
    input  logic                   IF_Flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    outPC,
    output logic [INSTR_WIDTH-1:0] outInstruction,
    output logic [1:0]             occupancy
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic                     out_valid_r;
    logic                     out_valid_s;
    logic                     in_ready_r;
    logic                     in_ready_nxt_s;
    logic                     in_ready_s;
    logic                     in_xfer_s;
    logic                     out_xfer_s;
    // The main entry is the output register itself; idle value is the bubble.
    logic [PC_WIDTH-1:0]      main_pc_r;
    logic [PC_WIDTH-1:0]      main_pc_s;
    logic [INSTR_WIDTH-1:0]   main_instr_r;
    logic [INSTR_WIDTH-1:0]   main_instr_s;
    logic [PC_WIDTH-1:0]      skid_pc_r;
    logic [PC_WIDTH-1:0]      skid_pc_s;
    logic [INSTR_WIDTH-1:0]   skid_instr_r;
    logic [INSTR_WIDTH-1:0]   skid_instr_s;

    // Select registered (skid) or combinational (single entry) ready.
    always_comb begin
        in_ready_s = 1'b0;
        if (SKID_EN) begin
            in_ready_s = in_ready_r;
        end else begin
            // Single entry can take a beat if empty or being drained this cycle.
            in_ready_s = ~out_valid_r | out_ready;
        end
    end

    // Handshake qualifiers.
    always_comb begin
        in_xfer_s  = in_valid & in_ready_s;
        out_xfer_s = out_valid_r & out_ready;
    end

    // Next-state and next-entry logic.
    always_comb begin
        state_s        = state_r;
        main_pc_s      = main_pc_r;
        main_instr_s   = main_instr_r;
        skid_pc_s      = skid_pc_r;
        skid_instr_s   = skid_instr_r;
        out_valid_s    = 1'b0;
        in_ready_nxt_s = 1'b1;

        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_s      = ST_ONE;
                    main_pc_s    = inPC;
                    main_instr_s = inInstruction;
                end else begin
                    state_s      = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    // Main drains and is refilled in the same edge.
                    main_pc_s    = inPC;
                    main_instr_s = inInstruction;
                end else if (in_xfer_s) begin
                    // Decode stalled: park the new beat behind main.
                    state_s      = ST_TWO;
                    skid_pc_s    = inPC;
                    skid_instr_s = inInstruction;
                end else if (out_xfer_s) begin
                    state_s      = ST_EMPTY;
                    main_pc_s    = {PC_WIDTH{1'b0}};
                    main_instr_s = NOP_INSTR;
                end else begin
                    state_s      = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain path exists.
                if (out_xfer_s) begin
                    state_s      = ST_ONE;
                    main_pc_s    = skid_pc_r;
                    main_instr_s = skid_instr_r;
                end else begin
                    state_s      = ST_TWO;
                end
            end
            default: begin
                state_s      = ST_EMPTY;
                main_pc_s    = {PC_WIDTH{1'b0}};
                main_instr_s = NOP_INSTR;
            end
        endcase

        // Flush overrides every transition and discards any offered beat.
        if (IF_Flush) begin
            state_s      = ST_EMPTY;
            main_pc_s    = {PC_WIDTH{1'b0}};
            main_instr_s = NOP_INSTR;
        end else begin
            state_s      = state_s;
        end

        out_valid_s    = (state_s != ST_EMPTY);
        in_ready_nxt_s = (state_s != ST_TWO);
    end

    // State and entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_EMPTY;
            out_valid_r  <= 1'b0;
            in_ready_r   <= 1'b1;
            main_pc_r    <= {PC_WIDTH{1'b0}};
            main_instr_r <= NOP_INSTR;
            skid_pc_r    <= {PC_WIDTH{1'b0}};
            skid_instr_r <= NOP_INSTR;
        end else begin
            state_r      <= state_s;
            out_valid_r  <= out_valid_s;
            in_ready_r   <= in_ready_nxt_s;
            main_pc_r    <= main_pc_s;
            main_instr_r <= main_instr_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_r;
    assign outPC          = main_pc_r;
    assign outInstruction = main_instr_r;
    assign occupancy      = state_r;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_pipe_reg
//
// Three instances: A (defaults, skid buffer), B (SKID_EN=0), C (16-bit
// fields, NOP 16'h0000). Stimulus pushes each beat that decode should see
// into a per-instance queue; a monitor on the falling edge pops and compares
// whenever an output transfer is presented.
// ---------------------------------------------------------------------------
module tb_if_id_pipe_reg;

    logic clk = 1'b0;
    logic rst;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [7:0]  a_inPC, a_outPC;
    logic [31:0] a_inInstr, a_outInstr;
    logic [1:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [7:0]  b_inPC, b_outPC;
    logic [31:0] b_inInstr, b_outInstr;
    logic [1:0]  b_occ;

    logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
    logic [15:0] c_inPC, c_outPC;
    logic [15:0] c_inInstr, c_outInstr;
    logic [1:0]  c_occ;

    logic [39:0] qa[$];
    logic [39:0] qb[$];
    logic [31:0] qc[$];

    int checks   = 0;
    int failures = 0;

    logic [31:0] strm [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};

    // Clock generation.
    always #5 clk = ~clk;

    if_id_pipe_reg u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .inPC(a_inPC), .inInstruction(a_inInstr), .IF_Flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .outPC(a_outPC),
        .outInstruction(a_outInstr), .occupancy(a_occ)
    );

    if_id_pipe_reg #(.SKID_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .inPC(b_inPC), .inInstruction(b_inInstr), .IF_Flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .outPC(b_outPC),
        .outInstruction(b_outInstr), .occupancy(b_occ)
    );

    if_id_pipe_reg #(.PC_WIDTH(16), .INSTR_WIDTH(16), .NOP_INSTR(16'h0000)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .inPC(c_inPC), .inInstruction(c_inInstr), .IF_Flush(c_flush),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .outPC(c_outPC),
        .outInstruction(c_outInstr), .occupancy(c_occ)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every presented output transfer.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_xfer", {a_outPC, a_outInstr}, 64'd0);
            else chk("a_xfer", {a_outPC, a_outInstr}, qa.pop_front());
        end
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_xfer", {b_outPC, b_outInstr}, 64'd0);
            else chk("b_xfer", {b_outPC, b_outInstr}, qb.pop_front());
        end
        if (c_out_valid && c_out_ready) begin
            if (qc.size() == 0) chk("c_unexpected_xfer", {c_outPC, c_outInstr}, 64'd0);
            else chk("c_xfer", {c_outPC, c_outInstr}, qc.pop_front());
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        rst = 1'b1;
        a_in_valid = 1'b1; a_inPC = 8'h55; a_inInstr = 32'h1234_5678; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_inPC = 8'h55; b_inInstr = 32'h1234_5678; b_flush = 1'b0; b_out_ready = 1'b0;
        c_in_valid = 1'b1; c_inPC = 16'h55; c_inInstr = 16'h1234; c_flush = 1'b0; c_out_ready = 1'b0;

        // Reset held two cycles with a beat offered.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        @(negedge clk);
        chk("rst_a_out_valid", a_out_valid, 1'b0);
        chk("rst_a_outInstr", a_outInstr, 32'hF800_0000);
        chk("rst_a_outPC", a_outPC, 8'h00);
        chk("rst_a_occ", a_occ, 2'd0);
        chk("rst_a_in_ready", a_in_ready, 1'b1);
        chk("rst_b_in_ready", b_in_ready, 1'b1);
        chk("rst_b_out_valid", b_out_valid, 1'b0);
        chk("rst_c_outInstr", c_outInstr, 16'h0000);
        chk("rst_c_in_ready", c_in_ready, 1'b1);

        // A: streaming with out_ready=1.
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1; a_inPC = 8'(i + 1); a_inInstr = strm[i];
            qa.push_back({8'(i + 1), strm[i]});
            @(negedge clk);
            if (i > 0) begin
                chk("stream_occ", a_occ, 2'd1);
                chk("stream_in_ready", a_in_ready, 1'b1);
            end
        end
        @(posedge clk); #1; a_in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_pc", a_outPC, 8'd3);
        chk("stream_last_occ", a_occ, 2'd1);
        @(posedge clk); @(negedge clk);
        chk("stream_drain_valid", a_out_valid, 1'b0);
        chk("stream_drain_nop", a_outInstr, 32'hF800_0000);
        chk("stream_drain_occ", a_occ, 2'd0);

        // A: stall into skid, offered beat held while full.
        @(posedge clk); #1;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_inPC = 8'd4; a_inInstr = 32'hAAAA_0004;
        qa.push_back({8'd4, 32'hAAAA_0004});
        @(posedge clk); #1;
        a_inPC = 8'd5; a_inInstr = 32'hBBBB_0005;
        qa.push_back({8'd5, 32'hBBBB_0005});
        @(negedge clk);
        chk("stall_one_instr", a_outInstr, 32'hAAAA_0004);
        chk("stall_one_in_ready", a_in_ready, 1'b1);
        @(posedge clk); #1;
        a_inPC = 8'd6; a_inInstr = 32'hCCCC_0006;
        @(negedge clk);
        chk("stall_two_occ", a_occ, 2'd2);
        chk("stall_two_in_ready", a_in_ready, 1'b0);
        chk("stall_two_instr", a_outInstr, 32'hAAAA_0004);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("stall_hold_occ", a_occ, 2'd2);
        chk("stall_hold_pc", a_outPC, 8'd4);
        @(posedge clk); #1;
        qa.push_back({8'd6, 32'hCCCC_0006});
        @(negedge clk);
        chk("skid_to_main_instr", a_outInstr, 32'hBBBB_0005);
        chk("skid_to_main_occ", a_occ, 2'd1);
        chk("skid_to_main_in_ready", a_in_ready, 1'b1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("held_beat_instr", a_outInstr, 32'hCCCC_0006);

        // A: flush in TWO with a beat offered.
        @(posedge clk); #1;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_inPC = 8'd7; a_inInstr = 32'hDDDD_0007;
        @(posedge clk); #1;
        a_inPC = 8'd8; a_inInstr = 32'hEEEE_0008;
        @(posedge clk); #1;
        a_inPC = 8'd9; a_inInstr = 32'h9999_0009; a_flush = 1'b1;
        @(negedge clk);
        chk("preflush_occ", a_occ, 2'd2);
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        chk("flush2_valid", a_out_valid, 1'b0);
        chk("flush2_nop", a_outInstr, 32'hF800_0000);
        chk("flush2_pc", a_outPC, 8'h00);
        chk("flush2_occ", a_occ, 2'd0);
        chk("flush2_in_ready", a_in_ready, 1'b1);
        repeat (2) @(negedge clk);
        chk("flush2_no_c", a_out_valid, 1'b0);

        // A: flush in ONE while in_ready=1, then back-to-back flush.
        @(posedge clk); #1;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_inPC = 8'd10; a_inInstr = 32'h0A0A_000A;
        @(posedge clk); #1;
        a_inPC = 8'd11; a_inInstr = 32'h0B0B_000B; a_flush = 1'b1;
        @(negedge clk);
        chk("flush1_in_ready", a_in_ready, 1'b1);
        @(posedge clk); #1;
        a_inPC = 8'd12; a_inInstr = 32'h0C0C_000C;
        @(negedge clk);
        chk("flush1_occ", a_occ, 2'd0);
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        @(negedge clk);
        chk("flushbb_occ", a_occ, 2'd0);
        chk("flushbb_valid", a_out_valid, 1'b0);
        chk("flushbb_nop", a_outInstr, 32'hF800_0000);

        // A: reset together with flush while stalled in TWO.
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_inPC = 8'd13; a_inInstr = 32'h0D0D_000D;
        @(posedge clk); #1;
        a_inPC = 8'd14; a_inInstr = 32'h0E0E_000E;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_pre_occ", a_occ, 2'd2);
        rst = 1'b1; a_flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_occ", a_occ, 2'd0);
        chk("rstmid_valid", a_out_valid, 1'b0);
        chk("rstmid_in_ready", a_in_ready, 1'b1);

        // B: single entry, combinational in_ready.
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_inPC = 8'h11; b_inInstr = 32'h1111_0011; b_out_ready = 1'b0;
        qb.push_back({8'h11, 32'h1111_0011});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        #1;
        chk("b_stall_in_ready", b_in_ready, 1'b0);
        chk("b_stall_occ", b_occ, 2'd1);
        #1;
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_inPC = 8'h12; b_inInstr = 32'h2222_0012;
        qb.push_back({8'h12, 32'h2222_0012});
        #1;
        chk("b_comb_in_ready", b_in_ready, 1'b1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_replace_instr", b_outInstr, 32'h2222_0012);
        chk("b_replace_occ", b_occ, 2'd1);
        @(posedge clk); @(negedge clk);
        chk("b_drain_occ", b_occ, 2'd0);

        // C: 16-bit streaming then flush.
        @(posedge clk); #1;
        c_out_ready = 1'b1; c_in_valid = 1'b1; c_inPC = 16'h0100; c_inInstr = 16'hBEEF;
        qc.push_back({16'h0100, 16'hBEEF});
        @(posedge clk); #1;
        c_inPC = 16'h0102; c_inInstr = 16'hCAFE;
        qc.push_back({16'h0102, 16'hCAFE});
        @(negedge clk);
        chk("c_stream_occ", c_occ, 2'd1);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        @(negedge clk);
        chk("c_stream_pc", c_outPC, 16'h0102);
        @(posedge clk); #1;
        c_out_ready = 1'b0; c_in_valid = 1'b1; c_inPC = 16'h0104; c_inInstr = 16'h1357;
        @(posedge clk); #1;
        c_flush = 1'b1; c_in_valid = 1'b0;
        @(negedge clk);
        chk("c_preflush_instr", c_outInstr, 16'h1357);
        @(posedge clk); #1;
        c_flush = 1'b0;
        @(negedge clk);
        chk("c_flush_valid", c_out_valid, 1'b0);
        chk("c_flush_nop", c_outInstr, 16'h0000);
        chk("c_flush_pc", c_outPC, 16'h0000);
        chk("c_flush_occ", c_occ, 2'd0);
        chk("c_flush_in_ready", c_in_ready, 1'b1);

        repeat (2) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Parametrised, flow-controlled successor of the basic IF/ID pipeline register.
- Sits between instruction fetch and decode, carrying PC and instruction with a valid/ready handshake.
- A 2-entry skid buffer lets the ID stage stall without combinational ready paths back into fetch.
- IF_Flush, used on taken branches and jumps, drops all buffered instructions and presents a NOP bubble.

Parameters:
- PC_WIDTH, 8, width of the PC field.
- INSTR_WIDTH, 32, width of the instruction field.
- NOP_INSTR, 32'hF800_0000, bubble encoding driven on outInstruction when no valid instruction is presented.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  register can accept a beat this cycle.
- inPC  input  PC_WIDTH  incremented PC from fetch.
- inInstruction  input  INSTR_WIDTH  fetched instruction.
- IF_Flush  input  1  discard all held and incoming instructions.
- out_valid  output  1  outPC/outInstruction hold a valid instruction.
- out_ready  input  1  ID stage accepts this cycle (0 = decode stall).
- outPC  output  PC_WIDTH  PC of the presented instruction; 0 when out_valid=0.
- outInstruction  output  INSTR_WIDTH  presented instruction; NOP_INSTR when out_valid=0.
- occupancy  output  2  number of held entries (0..2; max 1 when SKID_EN=0).

Behaviour:
- All outputs are registered except in_ready when SKID_EN=0.

Reset (rst=1 at edge):
- Both entries are invalidated: out_valid=0, outPC=0, outInstruction=NOP_INSTR, occupancy=0.
- in_ready=1 in the following cycle.
- rst has priority over every other input.

Handshake:
- Input transfer occurs when in_valid & in_ready.
- Output transfer occurs when out_valid & out_ready.
- Data inputs are don't-care when in_valid=0.
- While out_valid=1 and out_ready=0, outPC and outInstruction are held stable.

SKID_EN=1 (states EMPTY, ONE, TWO = main entry only, main + skid):
- in_ready = (state != TWO), registered.
- EMPTY + in xfer -> ONE. Beat loads main; visible next cycle.
- ONE + in xfer + out xfer -> ONE. Main is replaced by the new beat.
- ONE + in xfer, no out xfer -> TWO. Beat goes to skid.
- ONE + out xfer, no in -> EMPTY.
- TWO + out xfer -> ONE. Skid moves to main. No input is accepted, since in_ready=0.
- TWO, no out xfer -> TWO. Hold.
- Order is preserved: the skid entry is never presented before main.

SKID_EN=0:
- Single entry; in_ready = !out_valid | out_ready.
- occupancy is 0 or 1.

Flush:
- IF_Flush=1 at an edge forces state EMPTY, with the same output values as reset.
- Any input beat offered in that cycle is discarded, even if in_ready=1.
- An output transfer in the flush cycle still counts as consumed by ID.
- Flush while TWO drops both entries.
- in_ready=1 in the next cycle.
- Back-to-back flush cycles keep the block EMPTY.

Boundaries:
- in_valid=1 in TWO is ignored; fetch must hold its beat.
- Simultaneous rst and IF_Flush behaves as reset.
- Reset mid-stall discards held data.
- occupancy equals the state encoding at every cycle.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, inInstruction=32'h1234_5678 -> out_valid=0, outInstruction=32'hF800_0000, outPC=0, occupancy=0, in_ready=1 after release.
- Streaming: out_ready=1; send PC 1,2,3 with instructions A,B,C on consecutive cycles -> each appears one cycle later in order; occupancy stays at 1; in_ready remains 1.
- Stall/skid: hold out_ready=0 after A is presented; send B -> occupancy=2, in_ready=0, outInstruction stays A. Raise out_ready -> B is presented next cycle, then in_ready=1.
- Flush in TWO: state TWO with A,B; pulse IF_Flush while in_valid=1 offers C at PC 9 -> next cycle out_valid=0, outInstruction=NOP_INSTR, outPC=0, occupancy=0; C never appears.
- SKID_EN=0: out_ready=0 with one entry held -> in_ready=0 in the same cycle (combinational). out_ready=1 with simultaneous input D -> D replaces the entry next cycle.
- Parameter sweep: PC_WIDTH=16, INSTR_WIDTH=16, NOP_INSTR=16'h0000 -> streaming and flush scenarios pass with the new widths and bubble value.
